pool1_ctrl: RTL and testbench
=============================

# pool1_ctrl

First-layer 2×2 max-pooling engine that consumes the 28×28 feature map written by the conv1 stage into the f2 buffer. It generates f2 read addresses, performs a signed max over each non-overlapping 2×2 window, and writes the 14×14 result into the f3 buffer. Start/done handshake matches the conv stage so the top-level sequencer can chain layers.

## Interface
- DW, 16: feature data width, two's-complement signed.
- RD_LAT, 2: cycles from `f2_raddr` presentation to valid `f2_rdata`. Legal range is 1..4.

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset; single clock domain
- pool1_start  in  1  one-cycle start pulse; honoured only in IDLE
- f2_raddr  out  10  f2 buffer read address, 28-wide row stride
- f2_rdata  in  DW  f2 read data, valid RD_LAT cycles after address
- f3_waddr  out  8  f3 write address, 0..195
- f3_wdata  out  DW  pooled value
- f3_wr_en  out  1  one-cycle write strobe per output pixel
- pool1_done  out  1  one-cycle pulse after the last f3 write

## Operation
- FSM uses one-hot states IDLE=001, RUN=010, DONE=100.
  - IDLE→RUN when `pool1_start`=1.
  - RUN→DONE on the last count (`end_cnt3`).
  - DONE→IDLE unconditionally after one cycle.
  - Any illegal state returns to IDLE.
- Counters advance only in RUN and are cascaded:
  - cnt0: window column, 0..1
  - cnt1: window row, 0..1
  - cnt2: output column, 0..13
  - cnt3: output row, 0..13
  - Each counter wraps to 0 at its end value.
  - One RUN pass is 784 cycles.
- Read address: `f2_raddr` = (2·cnt3+cnt1)·28 + 2·cnt2 + cnt0. Compute it with shift/add only (28 = 16+8+4). No multiplier.
- Write address: `f3_waddr` = cnt3·14 + cnt2, also via shift/add (14 = 8+4+2).
- Max register, updated when the element's data is valid:
  - First element of a window (cnt0=cnt1=0, delayed to the data): load `f2_rdata`.
  - Other three elements: keep the signed maximum.
  - Equal values keep the held value.
- After the 4th element, drive `f3_wdata`, `f3_waddr` and `f3_wr_en` from registers, aligned in the same cycle.
- `pool1_start` in RUN or DONE is ignored, with no restart.
- `pool1_start` in IDLE while the previous pass's pipeline tail is still draining is accepted. Tail writes complete unaffected because delay lines are free-running.
- Arithmetic: addresses are unsigned and never exceed 783 / 195, so no overflow at 10 / 8 bits. The compare is DW-bit signed.

## Timing
- Start pulse sampled at cycle T. State is RUN at T+1. Element n (0..783) has its counter value in cycle T+1+n.
- `f2_raddr` for element n is registered and driven in cycle T+2+n.
- `f2_rdata` for element n is sampled in cycle T+2+n+RD_LAT.
- `f3_wr_en` is high in cycle T+3+n+RD_LAT for n=4m+3, i.e. one write every 4 cycles.
  - With RD_LAT=2: first write at T+8 to address 0, last write at T+788 to address 195.
- State is DONE at T+785. `pool1_done` is high in cycle T+787+RD_LAT (T+789 at default), exactly one cycle after the last write.
- Reset values: state=IDLE, all counters 0, `f2_raddr`=0, `f3_waddr`=0, `f3_wdata`=0, `f3_wr_en`=0, `pool1_done`=0.
- Reset mid-operation clears all delay-line control bits, including wr_en and done. No write or done pulse may escape after reset deassertion.

## Configuration
- `POOL1_RELU_EN`
  - Defined: `f3_wdata` = max(window, 0). Negative maxima are written as 0, with no added latency.
  - Undefined: the raw signed window max is written.
- Timing and addressing are identical in both builds.

## Test plan
- Ramp: f2[a]=a (RD_LAT=2), start at T → f3[0]=29, f3[1]=31, f3[14]=85, f3[195]=783. Exactly 196 wr_en pulses. First at T+8, done at T+789.
- All-negative window {-5,-2,-9,-3} at f2 addresses 0,1,28,29 → f3[0]=-2 without `POOL1_RELU_EN`, 0 with it.
- Ties/extremes: window {0x8000,0x7FFF,0x7FFF,0x8000} → f3_wdata=0x7FFF, a signed-compare check.
- Start pulses at T+10 and at T+785 (DONE) → ignored. Still exactly 196 writes and a single done pulse.
- `rst_n` low at T+400 for 3 cycles → all outputs 0 on assertion. No wr_en/done afterwards until a new start. A fresh start runs a full correct pass.
- Parameter RD_LAT=4 with the ramp → first write at T+10 with value 29, done at T+791.

Source files
------------

// File: rtl/pool1_ctrl_if.sv
// Bus bundle between pool1_ctrl and its f2/f3 buffers plus the sequencer start/done pair.
interface pool1_ctrl_if #(
    parameter int DW = 16
) ();
    logic          pool1_start;
    logic [9:0]    f2_raddr;
    logic [DW-1:0] f2_rdata;
    logic [7:0]    f3_waddr;
    logic [DW-1:0] f3_wdata;
    logic          f3_wr_en;
    logic          pool1_done;

    modport master (
        output pool1_start,
        output f2_rdata,
        input  f2_raddr,
        input  f3_waddr,
        input  f3_wdata,
        input  f3_wr_en,
        input  pool1_done
    );

    modport slave (
        input  pool1_start,
        input  f2_rdata,
        output f2_raddr,
        output f3_waddr,
        output f3_wdata,
        output f3_wr_en,
        output pool1_done
    );
endinterface

// File: rtl/pool1_ctrl.sv
// 2x2 signed max-pool of the 28x28 f2 map into the 14x14 f3 map.
// Optional build macro POOL1_RELU_EN clamps negative window maxima to zero.
module pool1_ctrl #(
    parameter int DW     = 16,
    parameter int RD_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    pool1_ctrl_if.slave  bus
);
    // state | meaning
    // IDLE  | waiting for pool1_start
    // RUN   | sweeping 784 read addresses
    // DONE  | one cycle before returning to IDLE
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        DONE = 3'b100
    } state_t;

    state_t r_state, w_state_nxt;

    logic        r_cnt0, r_cnt1;
    logic [3:0]  r_cnt2, r_cnt3;
    logic        w_run;
    logic        w_end_cnt0, w_end_cnt1, w_end_cnt2, w_end_cnt3;
    logic        w_first;
    logic [4:0]  w_row;
    logic [9:0]  w_row_ext;
    logic [9:0]  w_raddr;
    logic [7:0]  w_waddr;
    logic [7:0]  w_cnt3_ext;

    logic [RD_LAT:0] r_vld_d, r_first_d, r_lastw_d, r_lastp_d;
    logic [7:0]      r_wa_d [RD_LAT+1];

    logic signed [DW-1:0] w_rdata, w_max_nxt, w_wdata;
    logic signed [DW-1:0] r_max;
    logic [9:0]           r_raddr;
    logic [7:0]           r_waddr;
    logic [DW-1:0]        r_wdata;
    logic                 r_wr_en, r_done_pend, r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.pool1_start) w_state_nxt = RUN;
            RUN:     if (w_end_cnt3)      w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_run      = (r_state == RUN);
    assign w_end_cnt0 = w_run && r_cnt0;
    assign w_end_cnt1 = w_end_cnt0 && r_cnt1;
    assign w_end_cnt2 = w_end_cnt1 && (r_cnt2 == 4'd13);
    assign w_end_cnt3 = w_end_cnt2 && (r_cnt3 == 4'd13);
    assign w_first    = w_run && !r_cnt0 && !r_cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= 1'b0;
            r_cnt1 <= 1'b0;
            r_cnt2 <= 4'd0;
            r_cnt3 <= 4'd0;
        end else if (w_run) begin
            r_cnt0 <= ~r_cnt0;
            if (w_end_cnt0) r_cnt1 <= ~r_cnt1;
            if (w_end_cnt1) r_cnt2 <= w_end_cnt2 ? 4'd0 : r_cnt2 + 4'd1;
            if (w_end_cnt2) r_cnt3 <= w_end_cnt3 ? 4'd0 : r_cnt3 + 4'd1;
        end
    end

    // Row stride 28 = 16+8+4, output stride 14 = 8+4+2; shift/add keeps multipliers out.
    assign w_row      = {r_cnt3, 1'b0} + {4'd0, r_cnt1};
    assign w_row_ext  = {5'd0, w_row};
    assign w_raddr    = (w_row_ext << 4) + (w_row_ext << 3) + (w_row_ext << 2)
                      + {5'd0, r_cnt2, 1'b0} + {9'd0, r_cnt0};
    assign w_cnt3_ext = {4'd0, r_cnt3};
    assign w_waddr    = (w_cnt3_ext << 3) + (w_cnt3_ext << 2) + (w_cnt3_ext << 1)
                      + {4'd0, r_cnt2};

    // Free-running delay lines: a new pass may start while the previous tail drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raddr   <= '0;
            r_vld_d   <= '0;
            r_first_d <= '0;
            r_lastw_d <= '0;
            r_lastp_d <= '0;
            for (int i = 0; i <= RD_LAT; i++) r_wa_d[i] <= '0;
        end else begin
            r_raddr   <= w_raddr;
            r_vld_d   <= {r_vld_d[RD_LAT-1:0],   w_run};
            r_first_d <= {r_first_d[RD_LAT-1:0], w_first};
            r_lastw_d <= {r_lastw_d[RD_LAT-1:0], w_end_cnt1};
            r_lastp_d <= {r_lastp_d[RD_LAT-1:0], w_end_cnt3};
            r_wa_d[0] <= w_waddr;
            for (int i = 1; i <= RD_LAT; i++) r_wa_d[i] <= r_wa_d[i-1];
        end
    end

    assign w_rdata = $signed(bus.f2_rdata);

    always_comb begin
        w_max_nxt = r_max;
        if (r_first_d[RD_LAT])      w_max_nxt = w_rdata;
        else if (w_rdata > r_max)   w_max_nxt = w_rdata;
    end

`ifdef POOL1_RELU_EN
    assign w_wdata = w_max_nxt[DW-1] ? '0 : w_max_nxt;
`else
    assign w_wdata = w_max_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max       <= '0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_wr_en     <= 1'b0;
            r_done_pend <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (r_vld_d[RD_LAT]) r_max <= w_max_nxt;
            r_wr_en     <= r_vld_d[RD_LAT] && r_lastw_d[RD_LAT];
            r_done_pend <= r_vld_d[RD_LAT] && r_lastp_d[RD_LAT];
            r_done      <= r_done_pend;
            if (r_vld_d[RD_LAT] && r_lastw_d[RD_LAT]) begin
                r_wdata <= w_wdata;
                r_waddr <= r_wa_d[RD_LAT];
            end
        end
    end

    assign bus.f2_raddr   = r_raddr;
    assign bus.f3_waddr   = r_waddr;
    assign bus.f3_wdata   = r_wdata;
    assign bus.f3_wr_en   = r_wr_en;
    assign bus.pool1_done = r_done;
endmodule

// File: tb/tb_pool1_ctrl.sv
// Self-checking bench for pool1_ctrl: window table, ramp passes, start/reset corners, RD_LAT=4.
module tb_pool1_ctrl;
    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    pool1_ctrl_if #(.DW(16)) bus2 ();
    pool1_ctrl_if #(.DW(16)) bus4 ();

    pool1_ctrl #(.DW(16), .RD_LAT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    pool1_ctrl #(.DW(16), .RD_LAT(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] mem [0:783];
    logic [15:0] pipe2 [2];
    logic [15:0] pipe4 [4];

    always @(posedge clk) begin
        pipe2[0] <= mem[bus2.f2_raddr];
        pipe2[1] <= pipe2[0];
        pipe4[0] <= mem[bus4.f2_raddr];
        for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
    end
    assign bus2.f2_rdata = pipe2[1];
    assign bus4.f2_rdata = pipe4[3];

    logic signed [15:0] f3v2 [0:195];
    int                 f3c2 [0:195];
    int                 wr_cnt2, done_cnt2, done_cyc2;
    logic signed [15:0] f3v4 [0:195];
    int                 f3c4 [0:195];
    int                 wr_cnt4, done_cnt4, done_cyc4;

    always @(negedge clk) begin
        if (bus2.f3_wr_en) begin
            wr_cnt2 <= wr_cnt2 + 1;
            if (bus2.f3_waddr < 8'd196) begin
                f3v2[bus2.f3_waddr] <= $signed(bus2.f3_wdata);
                f3c2[bus2.f3_waddr] <= cyc;
            end
        end
        if (bus2.pool1_done) begin
            done_cnt2 <= done_cnt2 + 1;
            done_cyc2 <= cyc;
        end
    end

    always @(negedge clk) begin
        if (bus4.f3_wr_en) begin
            wr_cnt4 <= wr_cnt4 + 1;
            if (bus4.f3_waddr < 8'd196) begin
                f3v4[bus4.f3_waddr] <= $signed(bus4.f3_wdata);
                f3c4[bus4.f3_waddr] <= cyc;
            end
        end
        if (bus4.pool1_done) begin
            done_cnt4 <= done_cnt4 + 1;
            done_cyc4 <= cyc;
        end
    end

    typedef struct {
        string              name;
        logic signed [15:0] w0, w1, w2, w3;
        logic signed [15:0] exp_raw;
        logic signed [15:0] exp_relu;
    } win_t;

    win_t tbl [10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic pulse_start2(output int t);
        @(posedge clk); #1;
        bus2.pool1_start = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        bus2.pool1_start = 1'b0;
    endtask

    task automatic pulse_start4(output int t);
        @(posedge clk); #1;
        bus4.pool1_start = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        bus4.pool1_start = 1'b0;
    endtask

    task automatic wait_done2(input int t, input bit extra);
        int base;
        int n;
        base = done_cnt2;
        n = 0;
        while (done_cnt2 == base && n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (extra) bus2.pool1_start = (cyc == t + 10) || (cyc == t + 785);
        end
        bus2.pool1_start = 1'b0;
        chk("done2_wait_bound", (n < 2000) ? 1 : 0, 1);
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic wait_done4();
        int base;
        int n;
        base = done_cnt4;
        n = 0;
        while (done_cnt4 == base && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done4_wait_bound", (n < 2000) ? 1 : 0, 1);
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic check_ramp2(input int t, input string tag);
        int a;
        int act;
        for (int r = 0; r < 14; r++) begin
            for (int c = 0; c < 14; c++) begin
                a   = r * 14 + c;
                act = (f3c2[a] > t) ? int'(f3v2[a]) : -1;
                chk($sformatf("%s_f3[%0d]", tag, a), act, 56 * r + 2 * c + 29);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_raddr"}, int'(bus2.f2_raddr), 0);
        chk({tag, "_waddr"}, int'(bus2.f3_waddr), 0);
        chk({tag, "_wdata"}, int'(bus2.f3_wdata), 0);
        chk({tag, "_wr_en"}, int'(bus2.f3_wr_en), 0);
        chk({tag, "_done"},  int'(bus2.pool1_done), 0);
        chk({tag, "_wr_en4"}, int'(bus4.f3_wr_en), 0);
    endtask

    initial begin
        int t;
        int bw;
        int bd;
        logic signed [15:0] exp;

        tbl[0] = '{"all_neg",   -16'sd5, -16'sd2, -16'sd9, -16'sd3, -16'sd2, 16'sd0};
        tbl[1] = '{"extremes",  16'sh8000, 16'sh7FFF, 16'sh7FFF, 16'sh8000, 16'sh7FFF, 16'sh7FFF};
        tbl[2] = '{"ascend",    16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd4, 16'sd4};
        tbl[3] = '{"descend",   16'sd4, 16'sd3, 16'sd2, 16'sd1, 16'sd4, 16'sd4};
        tbl[4] = '{"all_m1",    -16'sd1, -16'sd1, -16'sd1, -16'sd1, -16'sd1, 16'sd0};
        tbl[5] = '{"all_min",   16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sd0};
        tbl[6] = '{"tie_first", 16'sd100, -16'sd200, 16'sd100, 16'sd50, 16'sd100, 16'sd100};
        tbl[7] = '{"zero_max",  -16'sd7, 16'sd0, -16'sd3, -16'sd9, 16'sd0, 16'sd0};
        tbl[8] = '{"max_first", 16'sh7FFF, -16'sd1, 16'sd0, 16'sd5, 16'sh7FFF, 16'sh7FFF};
        tbl[9] = '{"reload",    -16'sd9, -16'sd8, -16'sd10, -16'sd20, -16'sd8, 16'sd0};

        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus2.pool1_start = 1'b0;
        bus4.pool1_start = 1'b0;
        for (int a = 0; a < 784; a++) mem[a] = 16'd0;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Window table, one window per output column in the first output row
        for (int j = 0; j < 10; j++) begin
            mem[2*j]      = tbl[j].w0;
            mem[2*j + 1]  = tbl[j].w1;
            mem[28 + 2*j] = tbl[j].w2;
            mem[29 + 2*j] = tbl[j].w3;
        end
        pulse_start2(t);
        wait_done2(t, 1'b0);
        for (int j = 0; j < 10; j++) begin
`ifdef POOL1_RELU_EN
            exp = tbl[j].exp_relu;
`else
            exp = tbl[j].exp_raw;
`endif
            chk({"win_", tbl[j].name}, int'(f3v2[j]), int'(exp));
        end
        chk("win_zero_fill_f3[100]", int'(f3v2[100]), 0);

        // Ramp with ignored start pulses in RUN and DONE
        for (int a = 0; a < 784; a++) mem[a] = 16'(a);
        bw = wr_cnt2;
        bd = done_cnt2;
        pulse_start2(t);
        wait_done2(t, 1'b1);
        check_ramp2(t, "ramp");
        chk("ramp_wr_count",    wr_cnt2 - bw, 196);
        chk("ramp_done_count",  done_cnt2 - bd, 1);
        chk("ramp_first_wr",    f3c2[0] - t, 8);
        chk("ramp_last_wr",     f3c2[195] - t, 788);
        chk("ramp_done_cycle",  done_cyc2 - t, 789);

        // Reset in the middle of a pass
        pulse_start2(t);
        while (cyc < t + 400) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bw = wr_cnt2;
        bd = done_cnt2;
        repeat (900) @(posedge clk);
        #1;
        chk("midrst_no_wr",   wr_cnt2 - bw, 0);
        chk("midrst_no_done", done_cnt2 - bd, 0);

        bw = wr_cnt2;
        bd = done_cnt2;
        pulse_start2(t);
        wait_done2(t, 1'b0);
        check_ramp2(t, "fresh");
        chk("fresh_wr_count",   wr_cnt2 - bw, 196);
        chk("fresh_done_count", done_cnt2 - bd, 1);
        chk("fresh_done_cycle", done_cyc2 - t, 789);

        // Longer read latency
        bw = wr_cnt4;
        bd = done_cnt4;
        pulse_start4(t);
        wait_done4();
        chk("lat4_first_val",   (f3c4[0] > t) ? int'(f3v4[0]) : -1, 29);
        chk("lat4_last_val",    (f3c4[195] > t) ? int'(f3v4[195]) : -1, 783);
        chk("lat4_first_wr",    f3c4[0] - t, 10);
        chk("lat4_done_cycle",  done_cyc4 - t, 791);
        chk("lat4_wr_count",    wr_cnt4 - bw, 196);
        chk("lat4_done_count",  done_cnt4 - bd, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
